cfa_raster_scanner: RTL and testbench

//  Parametrised successor to the address + Bayer-colour pair. Scans a frame in raster order,
//  PPC pixels per beat, and emits per beat: linear address, row/col, CFA symbol per lane,

---
 rtl/cfa_pkg.sv | 35 +++
 rtl/cfa_phase_decode.sv | 28 ++
 rtl/cfa_raster_scanner.sv | 187 ++++++++++++++++++
 tb/tb_cfa_raster_scanner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
//------------------------------------------------------------------------------
// cfa_pkg : shared types and helpers for the CFA raster scanner
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cfa_pkg;

  typedef enum logic [1:0] {
    SYM_R  = 2'd0,
    SYM_GR = 2'd1,
    SYM_GB = 2'd2,
    SYM_B  = 2'd3
  } cfa_sym_e;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } cfa_pat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic int halo(input int filt);
    return filt / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfa_phase_decode.sv
//------------------------------------------------------------------------------
// cfa_phase_decode : row/col phase + pattern + mode -> CFA symbol (combinational)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cfa_phase_decode
  import cfa_pkg::*;
(
  input  logic [1:0] i_row_lsb,
  input  logic [1:0] i_col_lsb,
  input  logic [1:0] i_pattern,
  input  logic       i_quad,
  output logic [1:0] o_symbol
);

  logic w_rb;
  logic w_cb;

  // Quad-Bayer repeats each colour over a 2x2 cell, so phase moves up one bit
  assign w_rb = i_quad ? i_row_lsb[1] : i_row_lsb[0];
  assign w_cb = i_quad ? i_col_lsb[1] : i_col_lsb[0];

  assign o_symbol = {w_rb ^ i_pattern[1], w_cb ^ i_pattern[0]};

endmodule

`default_nettype wire

// File: rtl/cfa_raster_scanner.sv
//------------------------------------------------------------------------------
// cfa_raster_scanner : raster-order frame scanner emitting address, CFA symbols
//                      and border/SOF/EOL/EOF flags with valid/ready flow control
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cfa_raster_scanner
  import cfa_pkg::*;
#(
  parameter int ROW_W  = 11,
  parameter int COL_W  = 11,
  parameter int ADDR_W = 22,
  parameter int PPC    = 1,
  parameter int FILT   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ROW_W-1:0]  rowMax,
  input  logic [COL_W-1:0]  colMax,
  input  logic [1:0]        patternSelect,
  input  logic              quadMode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] address,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [2*PPC-1:0]  bayerSymbol,
  output logic [PPC-1:0]    border,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int HALO = halo(FILT);

  scan_state_e       r_state, w_state_n;
  logic [ROW_W-1:0]  r_row_max, w_row_max_n;
  logic [COL_W-1:0]  r_col_max, w_col_max_n;
  logic [1:0]        r_pat, w_pat_n;
  logic              r_quad, w_quad_n;

  logic              w_valid_n, w_done_n, w_cfg_err_n;
  logic [ROW_W-1:0]  w_row_n;
  logic [COL_W-1:0]  w_col_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic              w_xfer, w_misaligned;
  logic [COL_W:0]    w_cm1;
  logic              w_sof_n, w_eol_n, w_eof_n, w_row_edge_n;
  logic [PPC-1:0]    w_border_n;
  logic [2*PPC-1:0]  w_sym_n;

  assign w_xfer       = out_valid && out_ready;
  assign w_cm1        = {1'b0, colMax} + (COL_W+1)'(1);
  assign w_misaligned = (w_cm1 % (COL_W+1)'(PPC)) != '0;

  always_comb begin
    w_state_n   = r_state;
    w_row_max_n = r_row_max;
    w_col_max_n = r_col_max;
    w_pat_n     = r_pat;
    w_quad_n    = r_quad;
    w_valid_n   = out_valid;
    w_row_n     = row;
    w_col_n     = col;
    w_addr_n    = address;
    w_done_n    = 1'b0;
    w_cfg_err_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_misaligned) begin
            w_cfg_err_n = 1'b1;
          end else begin
            w_row_max_n = rowMax;
            w_col_max_n = colMax;
            w_pat_n     = patternSelect;
            w_quad_n    = quadMode;
            w_state_n   = ST_RUN;
            w_valid_n   = 1'b1;
            w_row_n     = '0;
            w_col_n     = '0;
            w_addr_n    = '0;
          end
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (eof) begin
            w_valid_n = 1'b0;
            w_done_n  = 1'b1;
            w_state_n = ST_DONE;
          end else begin
            w_addr_n = address + ADDR_W'(PPC);
            if (eol) begin
              w_col_n = '0;
              w_row_n = row + ROW_W'(1);
            end else begin
              w_col_n = col + COL_W'(PPC);
            end
          end
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
    if (abort) begin
      w_state_n   = ST_IDLE;
      w_valid_n   = 1'b0;
      w_done_n    = 1'b0;
      w_cfg_err_n = 1'b0;
    end
  end

  // Flags are derived from the next position so every output leaves a flop
  assign w_sof_n      = (w_row_n == '0) && (w_col_n == '0);
  assign w_eol_n      = ({1'b0, w_col_n} + (COL_W+1)'(PPC-1)) == {1'b0, w_col_max_n};
  assign w_eof_n      = w_eol_n && (w_row_n == w_row_max_n);
  assign w_row_edge_n = ({1'b0, w_row_n} < (ROW_W+1)'(HALO)) ||
                        (({1'b0, w_row_n} + (ROW_W+1)'(HALO)) > {1'b0, w_row_max_n});

  generate
    for (genvar gi = 0; gi < PPC; gi++) begin : g_lane
      logic [COL_W:0] w_c;
      assign w_c = {1'b0, w_col_n} + (COL_W+1)'(gi);
      assign w_border_n[gi] = w_row_edge_n || (w_c < (COL_W+1)'(HALO)) ||
                              ((w_c + (COL_W+1)'(HALO)) > {1'b0, w_col_max_n});
      cfa_phase_decode u_dec (
        .i_row_lsb (w_row_n[1:0]),
        .i_col_lsb (w_c[1:0]),
        .i_pattern (w_pat_n),
        .i_quad    (w_quad_n),
        .o_symbol  (w_sym_n[2*gi+1:2*gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row_max   <= '0;
      r_col_max   <= '0;
      r_pat       <= '0;
      r_quad      <= 1'b0;
      out_valid   <= 1'b0;
      address     <= '0;
      row         <= '0;
      col         <= '0;
      bayerSymbol <= '0;
      border      <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_row_max <= w_row_max_n;
      r_col_max <= w_col_max_n;
      r_pat     <= w_pat_n;
      r_quad    <= w_quad_n;
      out_valid <= w_valid_n;
      address   <= w_addr_n;
      row       <= w_row_n;
      col       <= w_col_n;
      sof       <= w_sof_n && w_valid_n;
      eol       <= w_eol_n && w_valid_n;
      eof       <= w_eof_n && w_valid_n;
      busy      <= (w_state_n != ST_IDLE);
      done      <= w_done_n;
      cfg_err   <= w_cfg_err_n;
      if (w_valid_n) begin
        bayerSymbol <= w_sym_n;
        border      <= w_border_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cfa_raster_scanner.sv
//------------------------------------------------------------------------------
// tb_cfa_raster_scanner : directed self-checking bench, PPC=1 and PPC=4 instances
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cfa_raster_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0, abort1 = 1'b0, abort4 = 1'b0;
  logic [10:0] rowMax_i = '0, colMax_i = '0;
  logic [1:0]  pat_i = '0;
  logic        quad_i = 1'b0, ready = 1'b1;

  logic        v1, sof1, eol1, eof1, busy1, done1, cerr1;
  logic [21:0] addr1;
  logic [10:0] row1, col1;
  logic [1:0]  sym1;
  logic [0:0]  bord1;
  logic        v4, sof4, eol4, eof4, busy4, done4, cerr4;
  logic [21:0] addr4;
  logic [10:0] row4, col4;
  logic [7:0]  sym4;
  logic [3:0]  bord4;

  int total = 0, bad = 0;
  bit sel = 1'b0;
  logic [7:0] sym_log [0:63];

  always #5 clk = ~clk;

  cfa_raster_scanner #(.ROW_W(11), .COL_W(11), .ADDR_W(22), .PPC(1), .FILT(5)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rowMax(rowMax_i), .colMax(colMax_i),
    .patternSelect(pat_i), .quadMode(quad_i), .out_ready(ready), .out_valid(v1), .address(addr1),
    .row(row1), .col(col1), .bayerSymbol(sym1), .border(bord1), .sof(sof1), .eol(eol1),
    .eof(eof1), .busy(busy1), .done(done1), .cfg_err(cerr1));

  cfa_raster_scanner #(.ROW_W(11), .COL_W(11), .ADDR_W(22), .PPC(4), .FILT(5)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .rowMax(rowMax_i), .colMax(colMax_i),
    .patternSelect(pat_i), .quadMode(quad_i), .out_ready(ready), .out_valid(v4), .address(addr4),
    .row(row4), .col(col4), .bayerSymbol(sym4), .border(bord4), .sof(sof4), .eol(eol4),
    .eof(eof4), .busy(busy4), .done(done4), .cfg_err(cerr4));

  logic        m_v, m_sof, m_eol, m_eof, m_busy, m_done;
  logic [21:0] m_addr;
  logic [10:0] m_row, m_col;
  logic [7:0]  m_sym;
  logic [3:0]  m_bord;

  always_comb begin
    if (sel) begin
      m_v = v4; m_sof = sof4; m_eol = eol4; m_eof = eof4; m_busy = busy4; m_done = done4;
      m_addr = addr4; m_row = row4; m_col = col4; m_sym = sym4; m_bord = bord4;
    end else begin
      m_v = v1; m_sof = sof1; m_eol = eol1; m_eof = eof1; m_busy = busy1; m_done = done1;
      m_addr = addr1; m_row = row1; m_col = col1; m_sym = {6'b0, sym1}; m_bord = {3'b0, bord1};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input bit s, input int rmax, input int cmax,
                           input logic [1:0] pat, input logic quad, input bit stall);
    int k = 0, cyc = 0, ppc, nbeats, base, r, c0;
    bit fin = 1'b0, prev_st = 1'b0;
    logic [63:0] got, exp, prev;
    logic [3:0] eb;
    sel = s;
    ppc = s ? 4 : 1;
    nbeats = (rmax + 1) * (cmax + 1) / ppc;
    rowMax_i = 11'(rmax); colMax_i = 11'(cmax); pat_i = pat; quad_i = quad;
    if (s) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    rowMax_i = '0; colMax_i = '0; pat_i = ~pat; quad_i = ~quad;
    chk("start_latency", {63'b0, m_v}, 64'd1);
    while (!fin && cyc < 4000) begin
      if (m_v) begin
        got = {12'b0, m_addr, m_row, m_col, m_sof, m_eol, m_eof, m_bord, m_busy};
        if (prev_st) chk("stall_hold", got, prev);
        base = k * ppc;
        r = base / (cmax + 1);
        c0 = base % (cmax + 1);
        eb = '0;
        for (int i = 0; i < ppc; i++)
          eb[i] = (r < 2) || (r > rmax - 2) || (c0 + i < 2) || (c0 + i > cmax - 2);
        exp = {12'b0, 22'(base), 11'(r), 11'(c0), (base == 0), (c0 + ppc - 1 == cmax),
               (c0 + ppc - 1 == cmax) && (r == rmax), eb, 1'b1};
        chk("beat", got, exp);
        if (k < 64) sym_log[k] = m_sym;
        ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_st = !ready;
        prev = got;
        if (ready) begin
          if (m_eof) fin = 1'b1;
          k++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ready = 1'b1;
    if (!fin) chk("timeout", 64'd0, 64'd1);
    chk("beat_count", 64'(k), 64'(nbeats));
    chk("eof_valid_drop", {63'b0, m_v}, 64'd0);
    chk("done_pulse", {63'b0, m_done}, 64'd1);
    @(negedge clk);
    chk("done_clear", {62'b0, m_done, m_busy}, 64'd0);
  endtask

  task automatic stop_test(input bit use_rst);
    sel = 1'b0;
    rowMax_i = 11'd3; colMax_i = 11'd3; pat_i = 2'd0; quad_i = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("beat5_addr", {42'b0, addr1}, 64'd5);
    if (use_rst) rst = 1'b1; else abort1 = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort1 = 1'b0;
    chk("stop_state", {61'b0, v1, busy1, done1}, 64'd0);
    @(negedge clk);
    chk("stop_no_done", {62'b0, done1, v1}, 64'd0);
    run_frame(1'b0, 3, 3, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d1", {40'b0, v1, busy1, done1, cerr1, sof1, eol1, eof1, addr1, bord1}, 64'd0);
    chk("rst_d4", {37'b0, v4, busy4, done4, cerr4, addr4, bord4}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {58'b0, v1, busy1, sof1, v4, busy4, sof4}, 64'd0);

    // 4x4 RGGB, one pixel per beat
    run_frame(1'b0, 3, 3, 2'd0, 1'b0, 1'b0);
    chk("t1_row0", {32'b0, sym_log[0], sym_log[1], sym_log[2], sym_log[3]}, 64'h00010001);
    chk("t1_row1", {32'b0, sym_log[4], sym_log[5], sym_log[6], sym_log[7]}, 64'h02030203);

    run_frame(1'b0, 3, 3, 2'd1, 1'b0, 1'b0);
    chk("t2_grbg", {56'b0, sym_log[0]}, 64'd1);
    run_frame(1'b0, 3, 3, 2'd2, 1'b0, 1'b0);
    chk("t2_gbrg", {56'b0, sym_log[0]}, 64'd2);
    run_frame(1'b0, 3, 3, 2'd3, 1'b0, 1'b0);
    chk("t2_bggr", {48'b0, sym_log[0], sym_log[1]}, 64'h0302);
    run_frame(1'b0, 3, 3, 2'd0, 1'b1, 1'b0);
    chk("t2_quad_r0", {32'b0, sym_log[0], sym_log[1], sym_log[2], sym_log[3]}, 64'h00000101);
    chk("t2_quad_r2", {32'b0, sym_log[8], sym_log[9], sym_log[10], sym_log[11]}, 64'h02020303);

    // Four pixels per beat, 8x2 frame
    run_frame(1'b1, 1, 7, 2'd0, 1'b0, 1'b0);
    chk("t3_lanes_r0", {48'b0, sym_log[0], sym_log[1]}, 64'h4444);
    chk("t3_lanes_r1", {48'b0, sym_log[2], sym_log[3]}, 64'hEEEE);

    sel = 1'b1;
    colMax_i = 11'd6; rowMax_i = 11'd1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("cfg_err_pulse", {61'b0, cerr4, busy4, v4}, 64'd4);
    @(negedge clk);
    chk("cfg_err_clear", {61'b0, cerr4, busy4, v4}, 64'd0);

    // Back-pressure
    run_frame(1'b0, 3, 5, 2'd2, 1'b0, 1'b1);
    run_frame(1'b1, 2, 7, 2'd1, 1'b1, 1'b1);

    // Borders and minimal frames
    run_frame(1'b0, 5, 5, 2'd0, 1'b0, 1'b0);
    run_frame(1'b1, 0, 3, 2'd0, 1'b0, 1'b0);
    run_frame(1'b0, 0, 0, 2'd3, 1'b0, 1'b0);

    stop_test(1'b0);
    stop_test(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
